// File: rtl/lsu_sq.sv
// Store queue: holds stores from allocation to commit, issues them to LSU_EX in commit order
// and broadcasts completed stores to the LQ. Optional load-hazard check: SQ_LOAD_HAZARD_EN.
module lsu_sq #(
  parameter int SQ_DEPTH     = 8,
  parameter int SQ_IDX_WIDTH = $clog2(SQ_DEPTH),
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int TAG_WIDTH    = 6,
  parameter int FUNC_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_flush,
  output logic                  o_full,
  input  logic                  i_alloc_en,
  input  logic [TAG_WIDTH-1:0]  i_alloc_tag,
  input  logic [ADDR_WIDTH-1:0] i_alloc_addr,
  input  logic [DATA_WIDTH-1:0] i_alloc_data,
  input  logic [FUNC_WIDTH-1:0] i_alloc_lsu_func,
  input  logic                  i_rob_retire_en,
  input  logic [TAG_WIDTH-1:0]  i_rob_retire_tag,
  input  logic                  i_issue_stall,
  output logic                  o_issue_en,
  output logic [ADDR_WIDTH-1:0] o_issue_addr,
  output logic [DATA_WIDTH-1:0] o_issue_data,
  output logic [FUNC_WIDTH-1:0] o_issue_lsu_func,
  output logic [TAG_WIDTH-1:0]  o_issue_tag,
  input  logic                  i_update_sq_en,
  input  logic                  i_update_sq_retry,
  input  logic                  i_mhq_fill,
  output logic                  o_sq_retire_en,
  output logic [ADDR_WIDTH-1:0] o_sq_retire_addr,
  output logic [FUNC_WIDTH-1:0] o_sq_retire_lsu_func
`ifdef SQ_LOAD_HAZARD_EN
  ,
  input  logic [ADDR_WIDTH-1:0] i_ld_addr,
  input  logic [FUNC_WIDTH-1:0] i_ld_lsu_func,
  output logic                  o_ld_hazard
`endif
);

  typedef enum logic [2:0] {
    S_INVALID, S_PENDING, S_COMMITTED, S_INFLIGHT, S_WAIT_FILL
  } slot_state_e;

  slot_state_e              state_q [SQ_DEPTH];
  slot_state_e              state_d [SQ_DEPTH];
  logic [TAG_WIDTH-1:0]     tag_q   [SQ_DEPTH];
  logic [TAG_WIDTH-1:0]     tag_d   [SQ_DEPTH];
  logic [ADDR_WIDTH-1:0]    addr_q  [SQ_DEPTH];
  logic [ADDR_WIDTH-1:0]    addr_d  [SQ_DEPTH];
  logic [DATA_WIDTH-1:0]    data_q  [SQ_DEPTH];
  logic [DATA_WIDTH-1:0]    data_d  [SQ_DEPTH];
  logic [FUNC_WIDTH-1:0]    func_q  [SQ_DEPTH];
  logic [FUNC_WIDTH-1:0]    func_d  [SQ_DEPTH];
  logic [SQ_IDX_WIDTH-1:0]  fifo_q  [SQ_DEPTH];
  logic [SQ_IDX_WIDTH-1:0]  fifo_d  [SQ_DEPTH];
  logic [SQ_IDX_WIDTH-1:0]  head_q, head_d, tail_q, tail_d;
  logic [SQ_IDX_WIDTH:0]    cnt_q, cnt_d;

  logic                     alloc_found, commit_found;
  logic [SQ_IDX_WIDTH-1:0]  alloc_idx, commit_idx, head_idx;
  logic                     fifo_nonempty, alloc_do, commit_do;
  logic                     head_inflight, complete_do, retry_do, fill_do;

  // Lowest-index free slot and lowest-index pending slot matching the committing tag.
  always_comb begin
    alloc_found  = 1'b0;
    alloc_idx    = '0;
    commit_found = 1'b0;
    commit_idx   = '0;
    for (int i = SQ_DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == S_INVALID) begin
        alloc_found = 1'b1;
        alloc_idx   = SQ_IDX_WIDTH'(i);
      end
      if (state_q[i] == S_PENDING && tag_q[i] == i_rob_retire_tag) begin
        commit_found = 1'b1;
        commit_idx   = SQ_IDX_WIDTH'(i);
      end
    end
  end

  // Only the FIFO head can ever be in flight or waiting for a fill.
  assign head_idx      = fifo_q[head_q];
  assign fifo_nonempty = (cnt_q != '0);
  assign head_inflight = fifo_nonempty && (state_q[head_idx] == S_INFLIGHT);
  assign o_full        = ~alloc_found;
  assign alloc_do      = i_alloc_en && alloc_found && ~i_flush;
  assign commit_do     = i_rob_retire_en && commit_found && ~i_flush;
  assign o_issue_en    = fifo_nonempty && (state_q[head_idx] == S_COMMITTED) && ~i_issue_stall;
  assign complete_do   = head_inflight && i_update_sq_en && ~i_update_sq_retry;
  assign retry_do      = head_inflight && i_update_sq_en && i_update_sq_retry;
  assign fill_do       = fifo_nonempty && (state_q[head_idx] == S_WAIT_FILL) && i_mhq_fill;

  assign o_issue_addr         = addr_q[head_idx];
  assign o_issue_data         = data_q[head_idx];
  assign o_issue_lsu_func     = func_q[head_idx];
  assign o_issue_tag          = tag_q[head_idx];
  assign o_sq_retire_en       = complete_do;
  assign o_sq_retire_addr     = addr_q[head_idx];
  assign o_sq_retire_lsu_func = func_q[head_idx];

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    data_d  = data_q;
    func_d  = func_q;
    fifo_d  = fifo_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (i_flush && state_q[i] == S_PENDING) state_d[i] = S_INVALID;
    end
    if (alloc_do) begin
      state_d[alloc_idx] = S_PENDING;
      tag_d[alloc_idx]   = i_alloc_tag;
      addr_d[alloc_idx]  = i_alloc_addr;
      data_d[alloc_idx]  = i_alloc_data;
      func_d[alloc_idx]  = i_alloc_lsu_func;
    end
    if (commit_do) begin
      state_d[commit_idx] = S_COMMITTED;
      fifo_d[tail_q]      = commit_idx;
      tail_d              = tail_q + 1'b1;
    end
    if (o_issue_en)  state_d[head_idx] = S_INFLIGHT;
    if (retry_do)    state_d[head_idx] = S_WAIT_FILL;
    if (fill_do)     state_d[head_idx] = S_COMMITTED;
    if (complete_do) begin
      state_d[head_idx] = S_INVALID;
      head_d            = head_q + 1'b1;
    end
    cnt_d = cnt_q + (SQ_IDX_WIDTH + 1)'(commit_do) - (SQ_IDX_WIDTH + 1)'(complete_do);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < SQ_DEPTH; i++) state_q[i] <= S_INVALID;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload and FIFO storage are qualified by slot state and count, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    addr_q <= addr_d;
    data_q <= data_d;
    func_q <= func_d;
    fifo_q <= fifo_d;
  end

`ifdef SQ_LOAD_HAZARD_EN
  localparam logic [FUNC_WIDTH-1:0] LSU_FUNC_SB = FUNC_WIDTH'(4'h8);
  localparam logic [FUNC_WIDTH-1:0] LSU_FUNC_SH = FUNC_WIDTH'(4'h9);

  function automatic logic [2:0] access_size(input logic [FUNC_WIDTH-1:0] f);
    if (f == LSU_FUNC_SB)      access_size = 3'd1;
    else if (f == LSU_FUNC_SH) access_size = 3'd2;
    else                       access_size = 3'd4;
  endfunction

  // Ranges are compared one bit wider so an access ending at the top of memory cannot wrap.
  always_comb begin
    logic [ADDR_WIDTH:0] ld_lo, ld_hi, st_lo, st_hi;
    o_ld_hazard = 1'b0;
    ld_lo = {1'b0, i_ld_addr};
    ld_hi = ld_lo + (ADDR_WIDTH + 1)'(access_size(i_ld_lsu_func));
    st_lo = '0;
    st_hi = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      st_lo = {1'b0, addr_q[i]};
      st_hi = st_lo + (ADDR_WIDTH + 1)'(access_size(func_q[i]));
      if (state_q[i] != S_INVALID && st_lo < ld_hi && ld_lo < st_hi) o_ld_hazard = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_sq.sv
// Scoreboard bench for lsu_sq: expected issues/retires are queued at commit and
// popped by a negedge monitor when the DUT produces them.
module tb_lsu_sq;
  localparam int AW = 32, DW = 32, TW = 6, FW = 4;
  localparam logic [FW-1:0] F_SB = 4'h8, F_SH = 4'h9, F_SW = 4'hA;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          i_flush, o_full, i_alloc_en;
  logic [TW-1:0] i_alloc_tag, i_rob_retire_tag, o_issue_tag;
  logic [AW-1:0] i_alloc_addr, o_issue_addr, o_sq_retire_addr;
  logic [DW-1:0] i_alloc_data, o_issue_data;
  logic [FW-1:0] i_alloc_lsu_func, o_issue_lsu_func, o_sq_retire_lsu_func;
  logic          i_rob_retire_en, i_issue_stall, o_issue_en;
  logic          i_update_sq_en, i_update_sq_retry, i_mhq_fill, o_sq_retire_en;
`ifdef SQ_LOAD_HAZARD_EN
  logic [AW-1:0] i_ld_addr;
  logic [FW-1:0] i_ld_lsu_func;
  logic          o_ld_hazard;
`endif

  always #5 clk = ~clk;

  lsu_sq dut (
    .clk(clk), .n_rst(n_rst), .i_flush(i_flush), .o_full(o_full),
    .i_alloc_en(i_alloc_en), .i_alloc_tag(i_alloc_tag), .i_alloc_addr(i_alloc_addr),
    .i_alloc_data(i_alloc_data), .i_alloc_lsu_func(i_alloc_lsu_func),
    .i_rob_retire_en(i_rob_retire_en), .i_rob_retire_tag(i_rob_retire_tag),
    .i_issue_stall(i_issue_stall), .o_issue_en(o_issue_en), .o_issue_addr(o_issue_addr),
    .o_issue_data(o_issue_data), .o_issue_lsu_func(o_issue_lsu_func), .o_issue_tag(o_issue_tag),
    .i_update_sq_en(i_update_sq_en), .i_update_sq_retry(i_update_sq_retry),
    .i_mhq_fill(i_mhq_fill), .o_sq_retire_en(o_sq_retire_en),
    .o_sq_retire_addr(o_sq_retire_addr), .o_sq_retire_lsu_func(o_sq_retire_lsu_func)
`ifdef SQ_LOAD_HAZARD_EN
    , .i_ld_addr(i_ld_addr), .i_ld_lsu_func(i_ld_lsu_func), .o_ld_hazard(o_ld_hazard)
`endif
  );

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [FW-1:0] func;
  } st_t;

  st_t mdl [64];
  st_t exp_iss[$];
  st_t exp_ret[$];
  st_t last_iss, e_iss, e_ret;
  int  n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: every issue and every retire must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (n_rst) begin
      if (o_issue_en) begin
        if (exp_iss.size() == 0) check("issue_unexpected", 32'(o_issue_tag), 32'hFFFF_FFFF);
        else begin
          e_iss    = exp_iss.pop_front();
          last_iss = e_iss;
          check("iss_tag",  32'(o_issue_tag), 32'(e_iss.tag));
          check("iss_addr", o_issue_addr, e_iss.addr);
          check("iss_data", o_issue_data, e_iss.data);
          check("iss_func", 32'(o_issue_lsu_func), 32'(e_iss.func));
        end
      end
      if (o_sq_retire_en) begin
        if (exp_ret.size() == 0) check("retire_unexpected", o_sq_retire_addr, 32'hFFFF_FFFF);
        else begin
          e_ret = exp_ret.pop_front();
          check("ret_addr", o_sq_retire_addr, e_ret.addr);
          check("ret_func", 32'(o_sq_retire_lsu_func), 32'(e_ret.func));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    i_alloc_en = 0; i_rob_retire_en = 0; i_update_sq_en = 0;
    i_update_sq_retry = 0; i_mhq_fill = 0; i_flush = 0;
  endtask

  task automatic alloc(input logic [TW-1:0] t, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [FW-1:0] f);
    i_alloc_en = 1; i_alloc_tag = t; i_alloc_addr = a; i_alloc_data = d; i_alloc_lsu_func = f;
    mdl[t] = '{tag: t, addr: a, data: d, func: f};
    tick();
  endtask

  task automatic set_commit(input logic [TW-1:0] t);
    i_rob_retire_en = 1; i_rob_retire_tag = t;
    exp_iss.push_back(mdl[t]);
    exp_ret.push_back(mdl[t]);
  endtask

  task automatic commit(input logic [TW-1:0] t);
    set_commit(t);
    tick();
  endtask

  task automatic wait_issue(input string tag, output int lat);
    bit seen = 0;
    lat = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (o_issue_en) seen = 1; else lat++;
      @(posedge clk);
      #1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic update(input logic retry);
    i_update_sq_en = 1; i_update_sq_retry = retry;
    if (retry) exp_iss.push_front(last_iss);
    tick();
  endtask

  task automatic peek_full(input string tag, input logic exp);
    @(negedge clk);
    check(tag, 32'(o_full), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_noissue(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check(tag, 32'(o_issue_en), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    n_rst = 0; i_flush = 0; i_alloc_en = 0; i_alloc_tag = '0; i_alloc_addr = '0;
    i_alloc_data = '0; i_alloc_lsu_func = '0; i_rob_retire_en = 0; i_rob_retire_tag = '0;
    i_issue_stall = 0; i_update_sq_en = 0; i_update_sq_retry = 0; i_mhq_fill = 0;
`ifdef SQ_LOAD_HAZARD_EN
    i_ld_addr = '0; i_ld_lsu_func = F_SB;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_full",   32'(o_full), 32'd0);
    check("rst_issue",  32'(o_issue_en), 32'd0);
    check("rst_retire", 32'(o_sq_retire_en), 32'd0);
    @(posedge clk); #1;
    n_rst = 1;
    tick();

    // Basic allocate / commit / issue / complete.
    alloc(6'd3, 32'h100, 32'hDEAD_BEEF, F_SW);
    commit(6'd3);
    wait_issue("t1_issue", lat);
    check("t1_issue_lat", 32'(lat), 32'd0);
    update(1'b0);
    idle_noissue("t1_idle", 2);

    // Fill all eight slots; ninth allocation is dropped.
    for (int i = 0; i < 7; i++) alloc(6'(10 + i), 32'h1000 + 32'(4 * i), 32'(i), F_SW);
    peek_full("t2_full7", 1'b0);
    alloc(6'd17, 32'h101C, 32'd7, F_SW);
    peek_full("t2_full8", 1'b1);
    alloc(6'd18, 32'h1020, 32'd8, F_SW);
    peek_full("t2_full9", 1'b1);
    commit(6'd10);
    wait_issue("t2_issue", lat);
    peek_full("t2_full_inflight", 1'b1);
    update(1'b0);
    peek_full("t2_full_freed", 1'b0);
    alloc(6'd19, 32'h1024, 32'd9, F_SW);
    peek_full("t2_full_refill", 1'b1);
    i_flush = 1; tick();
    peek_full("t2_full_flushed", 1'b0);

    // Commit order 5, 2, 7 with one store in flight at a time; commit + complete together.
    alloc(6'd5, 32'h300, 32'h5555_0005, F_SW);
    alloc(6'd2, 32'h304, 32'h2222_0002, F_SH);
    alloc(6'd7, 32'h308, 32'h7777_0007, F_SB);
    commit(6'd5);
    wait_issue("t3_issue5", lat);
    commit(6'd2);
    idle_noissue("t3_one_inflight", 2);
    set_commit(6'd7);
    update(1'b0);
    wait_issue("t3_issue2", lat);
    update(1'b0);
    wait_issue("t3_issue7", lat);
    update(1'b0);
    idle_noissue("t3_drained", 2);

    // Retry parks the store; a same-cycle fill is ignored, a later fill reissues it.
    alloc(6'd20, 32'h400, 32'hCAFE_0001, F_SW);
    commit(6'd20);
    wait_issue("t4_issue", lat);
    i_mhq_fill = 1;
    update(1'b1);
    idle_noissue("t4_wait_fill", 3);
    i_mhq_fill = 1; tick();
    wait_issue("t4_reissue", lat);
    check("t4_reissue_lat", 32'(lat), 32'd0);
    update(1'b0);

    // Flush drops pending stores only; allocate/commit in the flush cycle are ignored.
    i_issue_stall = 1;
    for (int i = 0; i < 6; i++) alloc(6'(30 + i), 32'h500 + 32'(4 * i), 32'h3000 + 32'(i), F_SW);
    commit(6'd30);
    commit(6'd31);
    idle_noissue("t5_stalled", 1);
    i_flush = 1;
    i_alloc_en = 1; i_alloc_tag = 6'd36; i_alloc_addr = 32'h600; i_alloc_data = '0; i_alloc_lsu_func = F_SW;
    i_rob_retire_en = 1; i_rob_retire_tag = 6'd32;
    tick();
    i_issue_stall = 0;
    wait_issue("t5_issue30", lat);
    update(1'b0);
    wait_issue("t5_issue31", lat);
    update(1'b0);
    idle_noissue("t5_no_extra", 3);
    peek_full("t5_full", 1'b0);
    for (int i = 0; i < 7; i++) alloc(6'(41 + i), 32'h700 + 32'(4 * i), 32'(i), F_SW);
    peek_full("t5_full7", 1'b0);
    alloc(6'd48, 32'h71C, 32'd7, F_SW);
    peek_full("t5_full8", 1'b1);
    i_flush = 1; tick();

    // Reset while full with a store in flight clears everything at once.
    for (int i = 0; i < 8; i++) alloc(6'(50 + i), 32'h800 + 32'(4 * i), 32'(i), F_SW);
    commit(6'd50);
    wait_issue("t6_issue", lat);
    #2 n_rst = 0;
    #1;
    check("t6_rst_full",  32'(o_full), 32'd0);
    check("t6_rst_issue", 32'(o_issue_en), 32'd0);
    exp_iss.delete();
    exp_ret.delete();
    tick();
    n_rst = 1;
    tick();
    alloc(6'd58, 32'h900, 32'h9999_0000, F_SH);
    commit(6'd58);
    wait_issue("t6_post_issue", lat);
    update(1'b0);

`ifdef SQ_LOAD_HAZARD_EN
    alloc(6'd60, 32'h200, 32'h1234_5678, F_SW);
    i_ld_addr = 32'h203; i_ld_lsu_func = F_SB; #1;
    check("hz_lb_203", 32'(o_ld_hazard), 32'd1);
    i_ld_addr = 32'h204; i_ld_lsu_func = F_SB; #1;
    check("hz_lb_204", 32'(o_ld_hazard), 32'd0);
    i_ld_addr = 32'h1FF; i_ld_lsu_func = F_SH; #1;
    check("hz_lh_1ff", 32'(o_ld_hazard), 32'd1);
    i_ld_addr = 32'h1FF; i_ld_lsu_func = F_SB; #1;
    check("hz_lb_1ff", 32'(o_ld_hazard), 32'd0);
    i_flush = 1; tick();
    i_ld_addr = 32'h203; #1;
    check("hz_flushed", 32'(o_ld_hazard), 32'd0);
`endif

    idle_noissue("end_idle", 2);
    check("end_iss_queue", 32'(exp_iss.size()), 32'd0);
    check("end_ret_queue", 32'(exp_ret.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
